muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit that sits between the register file read ports and its write port. It takes rs1/rs2 operands (rd1/rd2), runs a 32-step shift-add multiply or restoring divide, and returns the result with a one-cycle write strobe aimed at the register file write port (we3/a3/wd3). While it runs, the core stalls on `busy`.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_unit.sv | 217 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types, constants and helpers for the iterative RV32M
// multiply/divide unit.
//   muldiv_op_e    - funct3 encodings of the M-extension operations
//   muldiv_state_e - control states of the unit
//   MULDIV_ITERS   - number of shift-add / restoring-divide steps
//   abs32, neg64   - two's-complement magnitude and negation helpers
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    localparam int MULDIV_ITERS = 32;

    // Magnitude of a signed 32-bit value. 0x80000000 maps to itself, which
    // is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Runs a 32-step shift-add multiply or restoring divide on operand
// magnitudes, fixes up the sign at the end and strobes the result for one
// cycle towards the register file write port.
// Ports:
//   clk     - clock, all state changes on the rising edge
//   rst_n   - asynchronous active-low reset
//   start   - request a new operation (accepted only in IDLE)
//   op      - funct3 of the M-extension instruction
//   a, b    - rs1 / rs2 operand values
//   rd_in   - destination register index
//   kill    - abort an operation in flight
//   busy    - unit is not idle (core stalls)
//   done    - one-cycle result strobe (register file write enable)
//   rd_out  - destination index captured at accept time
//   result  - result value, valid while done is high
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] result
);

    muldiv_state_e state_reg;
    muldiv_op_e    op_reg;
    logic [4:0]    count_reg;
    // Multiply: {partial product high, multiplier shifting out low}.
    // Divide:   {partial remainder, dividend shifting into quotient}.
    logic [63:0]   acc_reg;
    // Multiplicand (multiply) or divisor (divide) magnitude.
    logic [31:0]   opnd_reg;
    // Final result must be negated (product/quotient sign, or remainder sign).
    logic          neg_reg;
    logic          done_reg;
    logic [4:0]    rd_reg;
    logic [31:0]   result_reg;

    // ------------------------------------------------------------------
    // Accept-time decode
    // ------------------------------------------------------------------
    muldiv_op_e  op_in;
    logic        a_signed;
    logic        b_signed;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        in_is_div;
    logic        in_is_rem;
    logic        div_zero;
    logic        div_ovf;
    logic        special;
    logic [31:0] special_res;
    logic        neg_next;
    logic [63:0] acc_init;
    logic [31:0] opnd_init;

    always_comb begin
        op_in     = muldiv_op_e'(op);
        a_signed  = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                    (op_in == OP_DIV)  || (op_in == OP_REM);
        b_signed  = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
        sign_a    = a_signed & a[31];
        sign_b    = b_signed & b[31];
        mag_a     = sign_a ? abs32(a) : a;
        mag_b     = sign_b ? abs32(b) : b;
        in_is_div = (op_in == OP_DIV) || (op_in == OP_DIVU) ||
                    (op_in == OP_REM) || (op_in == OP_REMU);
        in_is_rem = (op_in == OP_REM) || (op_in == OP_REMU);

        // A remainder takes the dividend's sign; everything else the XOR.
        neg_next  = (op_in == OP_REM) ? sign_a : (sign_a ^ sign_b);

        div_zero  = in_is_div && (b == 32'd0);
        div_ovf   = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                    (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        special   = div_zero || div_ovf;

        special_res = 32'd0;
        if (div_zero) begin
            special_res = in_is_rem ? a : 32'hFFFF_FFFF;
        end else if (div_ovf) begin
            special_res = in_is_rem ? 32'd0 : 32'h8000_0000;
        end

        if (in_is_div) begin
            acc_init  = {32'd0, mag_a};
            opnd_init = mag_b;
        end else begin
            acc_init  = {32'd0, mag_b};
            opnd_init = mag_a;
        end
    end

    // ------------------------------------------------------------------
    // One iteration step and final sign fix-up
    // ------------------------------------------------------------------
    logic        is_div;
    logic        is_rem;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] rem_sh;
    logic        div_ge;
    logic [31:0] rem_new;
    logic [63:0] div_next;
    logic [63:0] acc_next;
    logic [63:0] prod;
    logic [31:0] div_raw;
    logic [31:0] final_res;

    always_comb begin
        is_div = (op_reg == OP_DIV) || (op_reg == OP_DIVU) ||
                 (op_reg == OP_REM) || (op_reg == OP_REMU);
        is_rem = (op_reg == OP_REM) || (op_reg == OP_REMU);

        // Shift-add: add multiplicand into the high half when the current
        // multiplier bit is set, then shift the 65-bit sum right by one.
        mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
        mul_next = {mul_sum, acc_reg[31:1]};

        // Restoring divide: shift the next dividend bit into the remainder,
        // subtract the divisor when it fits and record the quotient bit.
        rem_sh   = {acc_reg[63:32], acc_reg[31]};
        div_ge   = (rem_sh >= {1'b0, opnd_reg});
        rem_new  = div_ge ? 32'(rem_sh - {1'b0, opnd_reg}) : rem_sh[31:0];
        div_next = {rem_new, acc_reg[30:0], div_ge};

        acc_next = is_div ? div_next : mul_next;

        prod     = neg_reg ? neg64(acc_next) : acc_next;
        div_raw  = is_rem ? acc_next[63:32] : acc_next[31:0];

        if (is_div) begin
            final_res = neg_reg ? (~div_raw + 32'd1) : div_raw;
        end else if (op_reg == OP_MUL) begin
            final_res = prod[31:0];
        end else begin
            final_res = prod[63:32];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            op_reg     <= OP_MUL;
            count_reg  <= 5'd0;
            acc_reg    <= 64'd0;
            opnd_reg   <= 32'd0;
            neg_reg    <= 1'b0;
            done_reg   <= 1'b0;
            rd_reg     <= 5'd0;
            result_reg <= 32'd0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // kill has no meaning here; start always wins.
                    if (start) begin
                        op_reg  <= op_in;
                        rd_reg  <= rd_in;
                        neg_reg <= neg_next;
                        if (special) begin
                            result_reg <= special_res;
                            done_reg   <= 1'b1;
                            state_reg  <= ST_DONE;
                        end else begin
                            acc_reg   <= acc_init;
                            opnd_reg  <= opnd_init;
                            count_reg <= 5'd0;
                            state_reg <= ST_ITER;
                        end
                    end
                end
                ST_ITER: begin
                    if (kill) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        acc_reg   <= acc_next;
                        count_reg <= count_reg + 5'd1;
                        if (count_reg == 5'(MULDIV_ITERS - 1)) begin
                            result_reg <= final_res;
                            done_reg   <= 1'b1;
                            state_reg  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_reg != ST_IDLE);
    assign done   = done_reg;
    assign rd_out = rd_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit. Results are predicted
// from plain 64-bit signed/unsigned arithmetic on the RV32M rules.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd_in;
    logic        kill;
    logic        busy;
    logic        done;
    logic [4:0]  rd_out;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .rd_in  (rd_in),
        .kill   (kill),
        .busy   (busy),
        .done   (done),
        .rd_out (rd_out),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model from the instruction definitions.
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint ux = longint'({32'd0, x});
        longint uy = longint'({32'd0, y});
        logic [63:0] p;
        logic        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = 64'(ux * uy); return p[31:0];  end
            3'd1: begin p = 64'(sx * sy); return p[63:32]; end
            3'd2: begin p = 64'(sx * uy); return p[63:32]; end
            3'd3: begin p = 64'(ux * uy); return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf)    return x;
                return 32'($signed(x) / $signed(y));
            end
            3'd5: begin
                if (y == 0) return 32'hFFFF_FFFF;
                return x / y;
            end
            3'd6: begin
                if (y == 0) return x;
                if (ovf)    return 32'd0;
                return 32'($signed(x) % $signed(y));
            end
            default: begin
                if (y == 0) return x;
                return x % y;
            end
        endcase
    endfunction

    // Edges from the accept edge to the edge that raises done.
    function automatic int ref_latency(input logic [2:0] o, input logic [31:0] x,
                                       input logic [31:0] y);
        if (o[2] && (y == 0)) return 0;
        if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
        return 32;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issues one operation from IDLE (called #1 after a rising edge) and
    // returns what the unit produced. Ends #1 after the edge that follows
    // the done cycle.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] r, output logic [31:0] res,
                         output logic [4:0] rdo, output int lat, output logic done_after);
        start = 1'b1; op = o; a = x; b = y; rd_in = r;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; rd_in = 5'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        rdo = rd_out;
        @(posedge clk); #1;
        done_after = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; rd_in = 5'd0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        checks++; if (rd_out !== 5'd0) begin errors++; $display("FAIL reset_rd_out got %0d want 0", rd_out); end
        $display("test_reset: busy=%b done=%b result=%h rd_out=%0d", busy, done, result, rd_out);
    endtask

    task automatic test_directed();
        logic [2:0]  t_op  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                    3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] t_a   [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                    32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                    32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] t_b   [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2,
                                    32'd2, 32'd2, 32'd7, 32'd7,
                                    32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] t_exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                    32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                    32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        int          t_lat [12] = '{32, 32, 32, 32, 32, 32, 32, 32, 0, 0, 0, 0};
        logic [31:0] res;
        logic [4:0]  rdo;
        logic [4:0]  rd;
        int          lat;
        logic        dn;
        for (int i = 0; i < 12; i++) begin
            rd = 5'((i * 3) % 32);
            do_op(t_op[i], t_a[i], t_b[i], rd, res, rdo, lat, dn);
            $display("directed %0d: op=%0d a=%h b=%h -> result=%h rd=%0d lat=%0d",
                     i, t_op[i], t_a[i], t_b[i], res, rdo, lat);
            checks++; if (res !== t_exp[i]) begin errors++;
                $display("FAIL directed_result[%0d] got %h want %h", i, res, t_exp[i]); end
            checks++; if (lat !== t_lat[i]) begin errors++;
                $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, t_lat[i]); end
            checks++; if (rdo !== rd) begin errors++;
                $display("FAIL directed_rd_out[%0d] got %0d want %0d", i, rdo, rd); end
            checks++; if (dn !== 1'b0) begin errors++;
                $display("FAIL directed_done_width[%0d] got %b want 0", i, dn); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x, y, res, exp_res;
        logic [4:0]  rd, rdo;
        int          lat, exp_lat;
        logic        dn;
        for (int i = 0; i < 48; i++) begin
            o  = 3'($urandom_range(0, 7));
            x  = pick_operand();
            y  = pick_operand();
            rd = 5'($urandom);
            exp_res = ref_model(o, x, y);
            exp_lat = ref_latency(o, x, y);
            do_op(o, x, y, rd, res, rdo, lat, dn);
            $display("random %0d: op=%0d a=%h b=%h -> result=%h expect=%h lat=%0d",
                     i, o, x, y, res, exp_res, lat);
            checks++; if (res !== exp_res) begin errors++;
                $display("FAIL random_result[%0d] op=%0d a=%h b=%h got %h want %h", i, o, x, y, res, exp_res); end
            checks++; if (lat !== exp_lat) begin errors++;
                $display("FAIL random_latency[%0d] got %0d want %0d", i, lat, exp_lat); end
            checks++; if (rdo !== rd) begin errors++;
                $display("FAIL random_rd_out[%0d] got %0d want %0d", i, rdo, rd); end
            checks++; if (dn !== 1'b0) begin errors++;
                $display("FAIL random_done_width[%0d] got %b want 0", i, dn); end
        end
    endtask

    task automatic test_start_ignored();
        logic [31:0] x = $urandom;
        logic [31:0] y = $urandom;
        logic [31:0] exp_res = ref_model(3'd0, x, y);
        int lat = 0;
        start = 1'b1; op = 3'd0; a = x; b = y; rd_in = 5'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; lat++; end
        start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd3; rd_in = 5'd9;
        @(posedge clk); #1; lat++;
        start = 1'b0;
        while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        $display("start_ignored: result=%h expect=%h rd=%0d lat=%0d", result, exp_res, rd_out, lat);
        checks++; if (result !== exp_res) begin errors++;
            $display("FAIL start_ignored_result got %h want %h", result, exp_res); end
        checks++; if (rd_out !== 5'd5) begin errors++;
            $display("FAIL start_ignored_rd_out got %0d want 5", rd_out); end
        checks++; if (lat !== 32) begin errors++;
            $display("FAIL start_ignored_latency got %0d want 32", lat); end
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL start_ignored_queued got busy=%b want 0", busy); end
    endtask

    task automatic test_kill();
        logic        seen = 1'b0;
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        logic        dn;
        start = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd7; rd_in = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        $display("kill: busy=%b done=%b", busy, done);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL kill_busy got %b want 0", busy); end
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL kill_no_done got %b want 0", seen); end
        do_op(3'd0, 32'd6, 32'd7, 5'd4, res, rdo, lat, dn);
        $display("after kill: result=%h lat=%0d", res, lat);
        checks++; if (res !== 32'd42) begin errors++; $display("FAIL kill_next_result got %h want 2a", res); end
        checks++; if (lat !== 32) begin errors++; $display("FAIL kill_next_latency got %0d want 32", lat); end

        // kill together with start in IDLE: start is accepted.
        kill = 1'b1; start = 1'b1; op = 3'd3; a = 32'hFFFF_FFFF; b = 32'd16; rd_in = 5'd8;
        @(posedge clk); #1;
        kill = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL kill_start_idle_busy got %b want 1", busy); end
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        $display("kill+start idle: result=%h lat=%0d", result, lat + 1);
        checks++; if (result !== 32'h0000_000F) begin errors++;
            $display("FAIL kill_start_idle_result got %h want 0000000f", result); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat = 0;
        logic        dn;
        start = 1'b1; op = 3'd5; a = 32'd1000; b = 32'd10; rd_in = 5'd1;
        @(posedge clk); #1;
        start = 1'b0;
        while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        checks++; if (result !== 32'd100) begin errors++; $display("FAIL b2b_first got %h want 64", result); end
        // start during the done cycle must be dropped.
        start = 1'b1; op = 3'd7; a = 32'd1000; b = 32'd7; rd_in = 5'd2;
        @(posedge clk); #1;
        start = 1'b0;
        $display("b2b: start in done cycle -> busy=%b done=%b", busy, done);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_start_in_done got busy=%b want 0", busy); end
        do_op(3'd7, 32'd1000, 32'd7, 5'd2, res, rdo, lat, dn);
        $display("b2b second: result=%h lat=%0d", res, lat);
        checks++; if (res !== 32'd6) begin errors++; $display("FAIL b2b_second got %h want 6", res); end
        checks++; if (lat !== 32) begin errors++; $display("FAIL b2b_second_latency got %0d want 32", lat); end
    endtask

    task automatic test_reset_mid();
        logic        seen = 1'b0;
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        logic        dn;
        start = 1'b1; op = 3'd4; a = 32'hFFFF_0000; b = 32'd3; rd_in = 5'd17;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        $display("reset mid-op: busy=%b done=%b result=%h rd_out=%0d", busy, done, result, rd_out);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b want 0", done); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL rst_mid_result got %h want 0", result); end
        checks++; if (rd_out !== 5'd0) begin errors++; $display("FAIL rst_mid_rd_out got %0d want 0", rd_out); end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done got %b want 0", seen); end
        do_op(3'd0, 32'd3, 32'd4, 5'd11, res, rdo, lat, dn);
        $display("after reset: MUL 3*4 result=%h rd=%0d lat=%0d", res, rdo, lat);
        checks++; if (res !== 32'd12) begin errors++; $display("FAIL rst_mid_next_result got %h want c", res); end
        checks++; if (rdo !== 5'd11) begin errors++; $display("FAIL rst_mid_next_rd got %0d want 11", rdo); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_kill();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
